// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame peak finder over the positive-frequency FFT bins.
// Squares each complex bin, tracks the strongest one, flags framing errors.
//
// Ports:
//   i_clk        rising-edge clock
//   i_reset_n    asynchronous active-low reset
//   i_ce         one FFT word valid per high cycle
//   i_result     {real, imag}, each IW-bit two's complement
//   i_sync       marks bin 0 of a frame (qualified by i_ce)
//   o_valid      one-cycle pulse when o_peak_bin/o_peak_mag update
//   o_peak_bin   index of the strongest bin of the last frame
//   o_peak_mag   re^2 + im^2 of that bin, unsigned
//   o_frame_err  one-cycle pulse on a sync misplacement
//
// Build option: FFT_PEAK_DC_REJECT_EN excludes bin 0 from the compare.

module fft_peak_detect #(
  parameter int IW    = 11,
  parameter int LGFFT = 10
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_ce,
  input  logic [2*IW-1:0]   i_result,
  input  logic              i_sync,
  output logic              o_valid,
  output logic [LGFFT-1:0]  o_peak_bin,
  output logic [2*IW-1:0]   o_peak_mag,
  output logic              o_frame_err
);

  localparam logic [LGFFT-1:0] LAST = '1;
  localparam logic [LGFFT-1:0] ONE  = 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [LGFFT-1:0] cnt, cnt_nx;
  logic             tag, tag_nx;
  logic             acc;
  logic [LGFFT-1:0] acc_bin;
  logic             err;
  logic             kill;

  // The frame tag toggles on every accepted sync. A framing error kills
  // only in-flight entries of the frame being abandoned, so a previous
  // frame's tail (including its bin N-1) still drains and publishes.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      tag   <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      tag   <= tag_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    tag_nx   = tag;
    acc      = 1'b0;
    acc_bin  = cnt;
    err      = 1'b0;
    kill     = 1'b0;
    if (i_ce) begin
      if (i_sync) begin
        if (state == RUN && cnt != LAST) begin
          err  = 1'b1;
          kill = 1'b1;
        end
        state_nx = RUN;
        cnt_nx   = '0;
        tag_nx   = ~tag;
        acc      = 1'b1;
        acc_bin  = '0;
      end else if (state == RUN) begin
        if (cnt == LAST) begin
          // Previous frame is already complete; only the stray strobe
          // is dropped and we wait for a fresh sync.
          err      = 1'b1;
          state_nx = IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx  = cnt + ONE;
          acc     = 1'b1;
          acc_bin = cnt + ONE;
        end
      end
    end
  end

  // S1: capture, components sign-extended to full product width
  logic                    s1_vld;
  logic signed [2*IW-1:0]  s1_re, s1_im;
  logic [LGFFT-1:0]        s1_bin;
  logic                    s1_tag;
  // S2: squares
  logic                    s2_vld;
  logic [2*IW-1:0]         s2_re2, s2_im2;
  logic [LGFFT-1:0]        s2_bin;
  logic                    s2_tag;
  // S3: magnitude
  logic                    s3_vld;
  logic [2*IW-1:0]         s3_mag;
  logic [LGFFT-1:0]        s3_bin;
  logic                    s3_tag;

  logic k1, k2, k3;

  assign k1 = kill && (s1_tag == tag);
  assign k2 = kill && (s2_tag == tag);
  assign k3 = kill && (s3_tag == tag);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      s1_vld <= 1'b0;
      s1_re  <= '0;
      s1_im  <= '0;
      s1_bin <= '0;
      s1_tag <= 1'b0;
      s2_vld <= 1'b0;
      s2_re2 <= '0;
      s2_im2 <= '0;
      s2_bin <= '0;
      s2_tag <= 1'b0;
      s3_vld <= 1'b0;
      s3_mag <= '0;
      s3_bin <= '0;
      s3_tag <= 1'b0;
    end else begin
      s1_vld <= acc;
      if (acc) begin
        s1_re  <= {{IW{i_result[2*IW-1]}}, i_result[2*IW-1:IW]};
        s1_im  <= {{IW{i_result[IW-1]}}, i_result[IW-1:0]};
        s1_bin <= acc_bin;
        s1_tag <= tag_nx;
      end
      s2_vld <= s1_vld && !k1;
      s2_re2 <= s1_re * s1_re;
      s2_im2 <= s1_im * s1_im;
      s2_bin <= s1_bin;
      s2_tag <= s1_tag;
      // Worst case 2^(2*IW-1): fits 2*IW bits unsigned
      s3_vld <= s2_vld && !k2;
      s3_mag <= s2_re2 + s2_im2;
      s3_bin <= s2_bin;
      s3_tag <= s2_tag;
    end
  end

  // S4: running max and frame close
  logic              live;
  logic              cons;
  logic              take;
  logic              close;
  logic              mx_vld;
  logic [LGFFT-1:0]  mx_bin;
  logic [2*IW-1:0]   mx_mag;
  logic              mx_tag;
  logic [LGFFT-1:0]  nx_bin;
  logic [2*IW-1:0]   nx_mag;
  logic              fin_vld;
  logic [LGFFT-1:0]  fin_bin;
  logic [2*IW-1:0]   fin_mag;

  always_comb begin
    live = s3_vld && !k3;
`ifdef FFT_PEAK_DC_REJECT_EN
    cons = live && !s3_bin[LGFFT-1] && (s3_bin != '0);
`else
    cons = live && !s3_bin[LGFFT-1];
`endif
    // Strictly greater: on ties the earlier (lower) bin is kept
    take   = cons && (!mx_vld || (s3_mag > mx_mag));
    nx_bin = take ? s3_bin : mx_bin;
    nx_mag = take ? s3_mag : mx_mag;
    close  = live && (s3_bin == LAST);
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mx_vld  <= 1'b0;
      mx_bin  <= '0;
      mx_mag  <= '0;
      mx_tag  <= 1'b0;
      fin_vld <= 1'b0;
      fin_bin <= '0;
      fin_mag <= '0;
    end else begin
      fin_vld <= close;
      if (close) begin
        fin_bin <= nx_bin;
        fin_mag <= nx_mag;
        mx_vld  <= 1'b0;
        mx_bin  <= '0;
        mx_mag  <= '0;
      end else if (kill && mx_tag == tag) begin
        mx_vld <= 1'b0;
        mx_bin <= '0;
        mx_mag <= '0;
      end else if (live) begin
        mx_vld <= mx_vld || cons;
        mx_bin <= nx_bin;
        mx_mag <= nx_mag;
        mx_tag <= s3_tag;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid     <= 1'b0;
      o_peak_bin  <= '0;
      o_peak_mag  <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid     <= fin_vld;
      o_frame_err <= err;
      if (fin_vld) begin
        o_peak_bin <= fin_bin;
        o_peak_mag <= fin_mag;
      end
    end
  end

endmodule
